// File: rtl/batch_dumper_pkg.sv
// Shared types and helpers for the batch dumper: FSM state encoding, data widths and
// a saturating counter increment.
package batch_dumper_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_SEND    = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/batch_dumper_sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous level into the local clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/batch_dumper.sv
// UART-side batch dumper: starts the collector, waits for its done flag, then reads the
// batch byte by byte and hands each byte to the UART transmitter with valid/ready.
module batch_dumper
  import batch_dumper_pkg::*;
#(
  parameter int unsigned BATCH_SIZE       = 1000,
  parameter int unsigned TIMEOUT_CYCLES   = 50000000,
  parameter int unsigned START_LOW_CYCLES = 16
) (
  input  logic              clk_uart,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic              abort,
  output logic              coll_start,
  input  logic              coll_done,
  output logic              read_enable,
  output logic [31:0]       read_addr,
  input  logic [BYTE_W-1:0] read_data,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              dump_done,
  output logic              error,
  output logic [31:0]       bytes_sent
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  txData_q, txData_d;
  logic               txValid_q, txValid_d;
  logic [CNT_W-1:0]   bytesSent_q, bytesSent_d;
  logic               error_q, error_d;
  logic               dumpDone_q, dumpDone_d;
  logic               doneSync;
  logic               active;
  logic               accept;
  logic               lowHoldMet;

  sync_2ff u_doneSync (
    .clk   (clk_uart),
    .rst_n (rst_n),
    .d_i   (coll_done),
    .q_o   (doneSync)
  );

  assign active     = (state_q == ST_ARM) || (state_q == ST_FETCH) ||
                      (state_q == ST_LATCH) || (state_q == ST_SEND);
  assign accept     = txValid_q && tx_ready;
  // cnt_q counts RELEASE cycles already completed before this one
  assign lowHoldMet = ({1'b0, cnt_q} + 33'd1) >= {1'b0, START_LOW_CYCLES};

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      txData_q    <= '0;
      txValid_q   <= 1'b0;
      bytesSent_q <= '0;
      error_q     <= 1'b0;
      dumpDone_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      txData_q    <= txData_d;
      txValid_q   <= txValid_d;
      bytesSent_q <= bytesSent_d;
      error_q     <= error_d;
      dumpDone_q  <= dumpDone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    txData_d    = txData_q;
    txValid_d   = txValid_q;
    bytesSent_d = bytesSent_q;
    error_d     = error_q;
    dumpDone_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dump_req && !abort) begin
          state_d     = ST_ARM;
          addr_d      = '0;
          cnt_d       = '0;
          bytesSent_d = '0;
          error_d     = 1'b0;
        end
      end
      ST_ARM: begin
        if (doneSync) begin
          state_d = ST_FETCH;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          error_d = 1'b1;
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = satInc(cnt_q);
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        txData_d  = read_data;
        txValid_d = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (accept) begin
          bytesSent_d = bytesSent_q + CNT_W'(1);
          txValid_d   = 1'b0;
          if (addr_q == CNT_W'(BATCH_SIZE - 1)) begin
            dumpDone_d = 1'b1;
            state_d    = ST_RELEASE;
            cnt_d      = '0;
          end else begin
            addr_d  = addr_q + CNT_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_RELEASE: begin
        if (!doneSync && lowHoldMet) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = satInc(cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte already handed over on this edge still counts, but the dump ends without done
    if (active && abort) begin
      txValid_d  = 1'b0;
      error_d    = 1'b1;
      dumpDone_d = 1'b0;
      addr_d     = addr_q;
      state_d    = ST_RELEASE;
      cnt_d      = '0;
    end
  end

  assign coll_start  = active;
  assign busy        = (state_q != ST_IDLE);
  assign read_enable = (state_q == ST_FETCH);
  assign read_addr   = addr_q;
  assign tx_data     = txData_q;
  assign tx_valid    = txValid_q;
  assign bytes_sent  = bytesSent_q;
  assign error       = error_q;
  assign dump_done   = dumpDone_q;

endmodule

// File: tb/tb_batch_dumper.sv
// Bench for batch_dumper: collector model on its own clock, transmitter back-pressure and a
// transaction-level scoreboard compared against the DUT on every clk_uart cycle.
module tb_batch_dumper;

  localparam int BATCH = 4;
  localparam int TMO   = 100;
  localparam int LOWC  = 16;

  logic        clk_uart    = 1'b0;
  logic        clk_collect = 1'b0;
  logic        rst_n;
  logic        dump_req;
  logic        abort;
  logic        coll_start;
  logic        coll_done;
  logic        read_enable;
  logic [31:0] read_addr;
  logic [7:0]  read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        dump_done;
  logic        error;
  logic [31:0] bytes_sent;

  logic [7:0] mem [BATCH];
  int  readyMode;
  bit  readyAlways;
  bit  collEnable;
  int  collDelay;
  int  collCnt;
  int  assertCount;
  int  failCount;

  int  accepts, armCount, lowCount, readCount, doneCount, startCount, cycleNo, lastAcceptCycle;
  bit  expError, readSeen, validSeen, hs, accepted, expDone;
  logic prevValid, prevReady, prevAbort, prevReq, prevBusy, prevCollStart, prevRead;
  logic [7:0] prevData;
  logic [7:0] acceptLog [$];

  batch_dumper #(
    .BATCH_SIZE       (BATCH),
    .TIMEOUT_CYCLES   (TMO),
    .START_LOW_CYCLES (LOWC)
  ) dut (
    .clk_uart    (clk_uart),
    .rst_n       (rst_n),
    .dump_req    (dump_req),
    .abort       (abort),
    .coll_start  (coll_start),
    .coll_done   (coll_done),
    .read_enable (read_enable),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .dump_done   (dump_done),
    .error       (error),
    .bytes_sent  (bytes_sent)
  );

  always #50 clk_uart = ~clk_uart;

  initial begin
    #3;
    forever #135 clk_collect = ~clk_collect;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Collector: raises done a few clk_collect cycles after seeing start, drops it when start falls
  initial begin
    coll_done = 1'b0;
    collCnt   = 0;
    forever begin
      @(posedge clk_collect);
      if (!coll_start || !collEnable) begin
        coll_done = 1'b0;
        collCnt   = 0;
      end else if (collCnt >= collDelay) begin
        coll_done = 1'b1;
      end else begin
        collCnt++;
      end
    end
  end

  initial begin
    read_data = 8'h00;
    forever begin
      @(negedge clk_uart);
      if (read_enable) read_data = mem[read_addr[1:0]];
    end
  end

  // Transmitter ready: 0 always, 1 one cycle in five, 2 random, otherwise never
  initial begin
    int phase;
    phase    = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk_uart);
      #20;
      case (readyMode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = (phase == 0);
          phase    = (phase + 1) % 5;
        end
        2: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: replays what happened on the previous edge from observed handshakes
  always @(negedge clk_uart) begin
    if (!rst_n) begin
      accepts = 0; expError = 0; armCount = 0; readSeen = 0; lowCount = LOWC;
      prevValid = 0; prevReady = 0; prevData = 0; prevAbort = 0; prevReq = 0;
      prevBusy = 0; prevCollStart = 0; prevRead = 0;
    end else begin
      cycleNo++;
      hs       = prevValid && prevReady;
      accepted = prevReq && !prevAbort && !prevBusy;
      expDone  = 1'b0;
      if (hs) begin
        if (accepts < BATCH) checkOutput("accepted byte", 32'(prevData), 32'(mem[2'(accepts)]));
        else checkOutput("bytes beyond batch", 32'(accepts), 32'(BATCH - 1));
        acceptLog.push_back(prevData);
        if (readyAlways && accepts > 0)
          checkOutput("cycles per byte", 32'(cycleNo - lastAcceptCycle), 32'd3);
        lastAcceptCycle = cycleNo;
        accepts++;
        expDone = (accepts == BATCH) && !(prevAbort && prevCollStart);
      end
      if (accepted) begin
        checkOutput("dump start busy", 32'(busy), 32'd1);
        checkOutput("dump start coll_start", 32'(coll_start), 32'd1);
        accepts = 0; expError = 0; armCount = 0; readSeen = 0; readCount = 0;
        doneCount = 0; validSeen = 0;
        acceptLog.delete();
        startCount++;
      end else if (!prevBusy) begin
        checkOutput("idle stays idle", 32'(busy), 32'd0);
      end
      if (coll_start && !prevCollStart) begin
        checkOutput("start low hold", 32'(lowCount >= LOWC), 32'd1);
        checkOutput("done low at start", 32'(coll_done), 32'd0);
      end
      if (prevAbort && prevCollStart) begin
        expError = 1;
        checkOutput("abort drops valid", 32'(tx_valid), 32'd0);
        checkOutput("abort releases", 32'(coll_start), 32'd0);
      end
      if (prevCollStart && !readSeen && armCount == TMO && !collEnable) begin
        expError = 1;
        checkOutput("timeout releases", 32'(coll_start), 32'd0);
      end
      if (prevCollStart && !coll_start)
        checkOutput("release reason", 32'(expError || accepts == BATCH), 32'd1);
      checkOutput("dump_done", 32'(dump_done), 32'(expDone));
      checkOutput("error", 32'(error), 32'(expError));
      checkOutput("bytes_sent", bytes_sent, 32'(accepts));
      if (prevValid && !prevReady && !(prevAbort && prevCollStart)) begin
        checkOutput("stall valid", 32'(tx_valid), 32'd1);
        checkOutput("stall data", 32'(tx_data), 32'(prevData));
      end
      if (tx_valid || read_enable) checkOutput("active while transferring", 32'(coll_start), 32'd1);
      if (coll_start) checkOutput("busy with start", 32'(busy), 32'd1);
      if (read_enable) begin
        checkOutput("read addr", read_addr, 32'(accepts));
        checkOutput("single read pulse", 32'(prevRead), 32'd0);
        checkOutput("no read while valid", 32'(tx_valid), 32'd0);
        readSeen = 1;
        readCount++;
      end
      if (coll_start && !readSeen) armCount++;
      lowCount = coll_start ? 0 : lowCount + 1;
      if (dump_done) doneCount++;
      if (tx_valid) validSeen = 1;
      prevValid = tx_valid; prevReady = tx_ready; prevData = tx_data; prevAbort = abort;
      prevReq = dump_req; prevBusy = busy; prevCollStart = coll_start; prevRead = read_enable;
    end
  end

  task automatic setReady(input int mode);
    readyMode   = mode;
    readyAlways = (mode == 0);
  endtask

  task automatic pulseReq();
    @(posedge clk_uart);
    #20 dump_req = 1'b1;
    @(posedge clk_uart);
    #20 dump_req = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_uart);
      n++;
    end while (busy && n < budget);
    #1;
    checkOutput("idle within budget", 32'(busy), 32'd0);
  endtask

  task automatic waitValid(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_uart);
      n++;
    end while (!tx_valid && n < budget);
    checkOutput("tx_valid within budget", 32'(tx_valid), 32'd1);
  endtask

  task automatic checkLog(input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    checkOutput("log size", 32'(acceptLog.size()), 32'd4);
    if (acceptLog.size() == 4) begin
      checkOutput("log byte0", 32'(acceptLog[0]), 32'(e0));
      checkOutput("log byte1", 32'(acceptLog[1]), 32'(e1));
      checkOutput("log byte2", 32'(acceptLog[2]), 32'(e2));
      checkOutput("log byte3", 32'(acceptLog[3]), 32'(e3));
    end
  endtask

  task automatic applyStimulus(input int mode);
    setReady(mode);
    pulseReq();
    waitIdle(2000);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int startsBefore;
    bit doAbort;
    rst_n = 1'b0; dump_req = 1'b0; abort = 1'b0;
    assertCount = 0; failCount = 0; cycleNo = 0; startCount = 0;
    collEnable = 1; collDelay = 3;
    setReady(0);
    mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'h00; mem[3] = 8'hFF;

    repeat (3) @(posedge clk_uart);
    #40;
    checkOutput("reset coll_start", 32'(coll_start), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset read_enable", 32'(read_enable), 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    checkOutput("reset dump_done", 32'(dump_done), 32'd0);
    checkOutput("reset bytes_sent", bytes_sent, 32'd0);
    checkOutput("reset read_addr", read_addr, 32'd0);
    @(posedge clk_uart);
    #20 rst_n = 1'b1;
    repeat (5) @(posedge clk_uart);

    $display("[TB] basic dump, transmitter always ready");
    applyStimulus(0);
    checkLog(8'hA5, 8'h5A, 8'h00, 8'hFF);
    checkOutput("t1 dump_done count", 32'(doneCount), 32'd1);
    checkOutput("t1 bytes_sent", bytes_sent, 32'd4);
    checkOutput("t1 error", 32'(error), 32'd0);
    checkOutput("t1 reads", 32'(readCount), 32'd4);

    $display("[TB] transmitter ready one cycle in five");
    applyStimulus(1);
    checkLog(8'hA5, 8'h5A, 8'h00, 8'hFF);
    checkOutput("t2 reads", 32'(readCount), 32'd4);
    checkOutput("t2 dump_done count", 32'(doneCount), 32'd1);

    $display("[TB] collector never done");
    collEnable = 0;
    applyStimulus(0);
    checkOutput("t3 error", 32'(error), 32'd1);
    checkOutput("t3 bytes_sent", bytes_sent, 32'd0);
    checkOutput("t3 no tx_valid", 32'(validSeen), 32'd0);
    checkOutput("t3 arm cycles", 32'(armCount), 32'd100);
    checkOutput("t3 dump_done count", 32'(doneCount), 32'd0);
    collEnable = 1;

    $display("[TB] abort after second byte");
    setReady(0);
    pulseReq();
    n = 0;
    do begin
      @(negedge clk_uart);
      #1;
      n++;
    end while (accepts < 2 && n < 500);
    checkOutput("t4 reach second byte", 32'(accepts), 32'd2);
    @(posedge clk_uart);
    #20 abort = 1'b1;
    @(posedge clk_uart);
    @(negedge clk_uart);
    #1;
    checkOutput("t4 error next cycle", 32'(error), 32'd1);
    checkOutput("t4 tx_valid next cycle", 32'(tx_valid), 32'd0);
    repeat (2) @(posedge clk_uart);
    #20 abort = 1'b0;
    waitIdle(2000);
    checkOutput("t4 bytes_sent", bytes_sent, 32'd2);
    checkOutput("t4 error sticky", 32'(error), 32'd1);
    checkOutput("t4 dump_done count", 32'(doneCount), 32'd0);
    @(posedge clk_uart);
    #20 abort = 1'b1;
    pulseReq();
    @(negedge clk_uart);
    checkOutput("t4 req under abort ignored", 32'(busy), 32'd0);
    #30 abort = 1'b0;

    $display("[TB] ignored requests and back-to-back dumps");
    startsBefore = startCount;
    setReady(1);
    pulseReq();
    waitValid(500);
    pulseReq();
    n = 0;
    do begin
      @(negedge clk_uart);
      n++;
    end while (!dump_done && n < 500);
    checkOutput("t5 first dump done", 32'(dump_done), 32'd1);
    pulseReq();
    waitIdle(2000);
    pulseReq();
    waitIdle(2000);
    checkOutput("t5 dumps started", 32'(startCount - startsBefore), 32'd2);
    checkLog(8'hA5, 8'h5A, 8'h00, 8'hFF);

    $display("[TB] asynchronous reset mid-transfer");
    setReady(3);
    pulseReq();
    waitValid(500);
    @(posedge clk_uart);
    #30 rst_n = 1'b0;
    #10;
    checkOutput("t6 coll_start", 32'(coll_start), 32'd0);
    checkOutput("t6 tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("t6 busy", 32'(busy), 32'd0);
    checkOutput("t6 bytes_sent", bytes_sent, 32'd0);
    checkOutput("t6 tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(posedge clk_uart);
    #20 rst_n = 1'b1;
    repeat (30) @(posedge clk_uart);
    applyStimulus(0);
    checkLog(8'hA5, 8'h5A, 8'h00, 8'hFF);
    checkOutput("t6 dump_done count", 32'(doneCount), 32'd1);

    $display("[TB] randomized dumps");
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < BATCH; i++) mem[i] = 8'($urandom);
      collDelay = $urandom_range(2, 6);
      setReady($urandom_range(0, 2));
      doAbort = ($urandom_range(0, 3) == 0);
      pulseReq();
      repeat ($urandom_range(1, 12)) @(posedge clk_uart);
      #20;
      if (doAbort) abort = 1'b1;
      else dump_req = 1'b1;
      @(posedge clk_uart);
      #20;
      abort    = 1'b0;
      dump_req = 1'b0;
      waitIdle(2000);
      if (!doAbort) begin
        checkOutput("random bytes_sent", bytes_sent, 32'd4);
        checkOutput("random dump_done count", 32'(doneCount), 32'd1);
      end
    end

    repeat (5) @(posedge clk_uart);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
